// File: rtl/ov_dvp_gen_pkg.sv
// Shared definitions for the DVP sensor source: FSM states, test pattern codes
// and a counter-width helper.
package ov_dvp_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_VSYNC  = 3'd1,
        ST_VBACK  = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_VFRONT = 3'd4
    } ov_state_t;

    localparam logic [1:0] PAT_RAMP  = 2'd0;
    localparam logic [1:0] PAT_BARS  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_TAG   = 2'd3;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ov_dvp_gen_pat.sv
// Combinational test pattern generator: maps pattern code, column, row parity
// and frame tag to one pixel byte. The parent registers and href-gates it.
module ov_dvp_gen_pat
    import ov_dvp_gen_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int COL_W    = 10
) (
    input  logic [1:0]       pattern,
    input  logic [COL_W-1:0] col,
    input  logic             row_lsb,
    input  logic [7:0]       frame_tag,
    output logic [7:0]       pixel
);

    logic [7:0] col8;
    logic [2:0] bar;

    // Column truncated to a byte, and the bar index (8 equal bars across the line).
    always_comb begin
        col8 = 8'(col);
        bar  = 3'((32'(col) * 32'd8) / 32'(H_ACTIVE));
    end

    // Pattern select.
    always_comb begin
        pixel = 8'h00;
        case (pattern)
            PAT_RAMP:  pixel = col8;
            PAT_BARS:  pixel = {bar, 5'b0_0000};
            PAT_CHECK: pixel = (row_lsb ^ col[0]) ? 8'hFF : 8'h00;
            PAT_TAG:   pixel = col8 ^ frame_tag;
            default:   pixel = 8'h00;
        endcase
    end

endmodule

// File: rtl/ov_dvp_gen.sv
// OV-style DVP source: pclk divider, line/frame counters, frame FSM and the
// registered vsync/href/data outputs, all of which change on pclk falling edges.
module ov_dvp_gen
    import ov_dvp_gen_pkg::*;
#(
    parameter int PCLK_DIV = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BACK   = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        ov_pclk,
    output logic        ov_vsync,
    output logic        ov_href,
    output logic [7:0]  ov_data,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_MAX01 = (VS_LINES > V_BACK) ? VS_LINES : V_BACK;
    localparam int V_MAX23 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX   = (V_MAX01 > V_MAX23) ? V_MAX01 : V_MAX23;
    localparam int PC_W    = cnt_width(PCLK_DIV);
    localparam int H_W     = cnt_width(H_TOTAL);
    localparam int V_W     = cnt_width(V_MAX);

    logic [PC_W-1:0] pc_reg, pc_next;
    logic            tick;
    logic            pclk_reg;

    ov_state_t       state_reg, state_next;
    logic [H_W-1:0]  h_cnt_reg, h_next;
    logic [V_W-1:0]  v_cnt_reg, v_next;
    logic [1:0]      pat_reg;
    logic            line_end, last_line, frame_end, latch_pat, href_next;

    logic            vsync_reg, href_reg, frame_done_reg;
    logic [7:0]      data_reg, pixel;
    logic [15:0]     frame_cnt_reg;

    // Divider next value; a tick marks the pclk falling edge.
    always_comb begin
        tick    = (pc_reg == PC_W'(PCLK_DIV - 1));
        pc_next = tick ? '0 : pc_reg + PC_W'(1);
    end

    // Free-running divider and registered pclk (low for the first half period).
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg   <= '0;
            pclk_reg <= 1'b0;
        end else begin
            pc_reg   <= pc_next;
            pclk_reg <= (pc_next >= PC_W'(PCLK_DIV / 2));
        end
    end

    // Next state and counters; a state ends on the last pclk of its last line.
    always_comb begin
        state_next = state_reg;
        h_next     = h_cnt_reg;
        v_next     = v_cnt_reg;
        frame_end  = 1'b0;
        latch_pat  = 1'b0;
        last_line  = 1'b0;
        line_end   = (h_cnt_reg == H_W'(H_TOTAL - 1));
        case (state_reg)
            ST_VSYNC:  last_line = (v_cnt_reg == V_W'(VS_LINES - 1));
            ST_VBACK:  last_line = (v_cnt_reg == V_W'(V_BACK - 1));
            ST_ACTIVE: last_line = (v_cnt_reg == V_W'(V_ACTIVE - 1));
            ST_VFRONT: last_line = (v_cnt_reg == V_W'(V_FRONT - 1));
            default:   last_line = 1'b0;
        endcase
        if (state_reg == ST_IDLE) begin
            h_next = '0;
            v_next = '0;
            if (en) begin
                state_next = ST_VSYNC;
                latch_pat  = 1'b1;
            end
        end else begin
            h_next = line_end ? '0 : h_cnt_reg + H_W'(1);
            if (line_end) begin
                if (last_line) begin
                    v_next = '0;
                    case (state_reg)
                        ST_VSYNC:  state_next = (V_BACK > 0) ? ST_VBACK : ST_ACTIVE;
                        ST_VBACK:  state_next = ST_ACTIVE;
                        ST_ACTIVE: begin
                            if (V_FRONT > 0) state_next = ST_VFRONT;
                            else             frame_end  = 1'b1;
                        end
                        ST_VFRONT: frame_end = 1'b1;
                        default:   state_next = ST_IDLE;
                    endcase
                    if (frame_end) begin
                        state_next = en ? ST_VSYNC : ST_IDLE;
                        latch_pat  = en;
                    end
                end else begin
                    v_next = v_cnt_reg + V_W'(1);
                end
            end
        end
        href_next = (state_next == ST_ACTIVE) && (h_next < H_W'(H_ACTIVE));
    end

    // State, counters and latched pattern advance only on ticks.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            h_cnt_reg <= '0;
            v_cnt_reg <= '0;
            pat_reg   <= '0;
        end else if (tick) begin
            state_reg <= state_next;
            h_cnt_reg <= h_next;
            v_cnt_reg <= v_next;
            if (latch_pat) pat_reg <= pattern_sel;
        end
    end

    ov_dvp_gen_pat #(
        .H_ACTIVE (H_ACTIVE),
        .COL_W    (H_W)
    ) u_pat (
        .pattern   (pat_reg),
        .col       (h_next),
        .row_lsb   (v_next[0]),
        .frame_tag (frame_cnt_reg[7:0]),
        .pixel     (pixel)
    );

    // Video outputs describe the pclk period that starts at this tick.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            vsync_reg      <= 1'b0;
            href_reg       <= 1'b0;
            data_reg       <= 8'h00;
            frame_done_reg <= 1'b0;
            frame_cnt_reg  <= 16'h0000;
        end else begin
            frame_done_reg <= tick && frame_end;
            if (tick) begin
                vsync_reg <= (state_next == ST_VSYNC);
                href_reg  <= href_next;
                data_reg  <= href_next ? pixel : 8'h00;
                if (frame_end) frame_cnt_reg <= frame_cnt_reg + 16'd1;
            end
        end
    end

    assign ov_pclk    = pclk_reg;
    assign ov_vsync   = vsync_reg;
    assign ov_href    = href_reg;
    assign ov_data    = data_reg;
    assign frame_done = frame_done_reg;
    assign frame_cnt  = frame_cnt_reg;

endmodule

// File: tb/tb_ov_dvp_gen.sv
// Directed bench for ov_dvp_gen with a small frame (8+4 pclks x 2+1+3+1 lines).
module tb_ov_dvp_gen;

    localparam int H_ACT       = 8;
    localparam int H_TOT       = 12;
    localparam int FRAME_PCLKS = 84;

    logic        clk_sys = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        ov_pclk, ov_vsync, ov_href, frame_done;
    logic [7:0]  ov_data;
    logic [15:0] frame_cnt;

    int          chk_cnt = 0;
    int          pass_cnt = 0;
    int          fd_cnt = 0;
    int          run_len = 0;
    logic        prev_pclk = 1'b0;
    logic [9:0]  prev_vec = '0;
    logic        rose = 1'b0;

    ov_dvp_gen #(
        .PCLK_DIV (4),
        .H_ACTIVE (8),
        .H_BLANK  (4),
        .VS_LINES (2),
        .V_BACK   (1),
        .V_ACTIVE (3),
        .V_FRONT  (1)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .en          (en),
        .pattern_sel (pattern_sel),
        .ov_pclk     (ov_pclk),
        .ov_vsync    (ov_vsync),
        .ov_href     (ov_href),
        .ov_data     (ov_data),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clk_sys cycle, sampled on the falling edge.
    task automatic step();
        logic [9:0] vec;
        @(negedge clk_sys);
        vec       = {ov_vsync, ov_href, ov_data};
        run_len   = (vec === prev_vec) ? run_len + 1 : 0;
        prev_vec  = vec;
        rose      = ov_pclk && !prev_pclk;
        prev_pclk = ov_pclk;
        if (frame_done) fd_cnt++;
    endtask

    task automatic get_rise();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 16 && !got; i++) begin
            step();
            got = rose;
        end
        if (!got) chk("pclk_rise_timeout", 32'(0), 32'(1));
    endtask

    // Expected {vsync, href, data} for pclk k of a frame.
    function automatic logic [9:0] exp_vec(input int pat, input int k, input int fc);
        int line, h, row;
        logic vs, hr;
        logic [7:0] d;
        line = k / H_TOT;
        h    = k % H_TOT;
        row  = line - 3;
        vs   = (line < 2);
        hr   = (line >= 3) && (line < 6) && (h < H_ACT);
        d    = 8'h00;
        if (hr) begin
            case (pat)
                0: d = 8'(h);
                1: d = 8'((h * 8 / H_ACT) * 32);
                2: d = (((row ^ h) & 1) != 0) ? 8'hFF : 8'h00;
                3: d = 8'(h) ^ 8'(fc);
                default: d = 8'h00;
            endcase
        end
        return {vs, hr, d};
    endfunction

    task automatic check_rise(input int pat, input int k, input int fc);
        get_rise();
        $display("fc=%0d k=%0d vsync=%0b href=%0b data=%02h", fc, k, ov_vsync, ov_href, ov_data);
        chk($sformatf("fc%0d_k%0d_vsync_href_data", fc, k),
            32'({ov_vsync, ov_href, ov_data}), 32'(exp_vec(pat, k, fc)));
        chk($sformatf("fc%0d_k%0d_setup", fc, k), 32'(run_len >= 2), 32'(1));
    endtask

    task automatic start_frame(input int pat, input int fc, input int fd_exp);
        check_rise(pat, 0, fc);
        chk($sformatf("fc%0d_frame_done_count", fc), 32'(fd_cnt), 32'(fd_exp));
        chk($sformatf("fc%0d_frame_cnt", fc), 32'(frame_cnt), 32'(fc));
    endtask

    // Remaining pclks of a frame; inputs change right after pclk act_k.
    task automatic check_frame(input int pat, input int fc, input int act_k,
                               input logic act_en, input logic [1:0] act_pat);
        for (int k = 1; k < FRAME_PCLKS; k++) begin
            check_rise(pat, k, fc);
            if (k == act_k) begin
                en          = act_en;
                pattern_sel = act_pat;
            end
        end
        chk($sformatf("fc%0d_no_early_frame_done", fc), 32'(fd_cnt), 32'(fc));
    endtask

    task automatic check_idle(input int n, input int fc);
        for (int i = 0; i < n; i++) begin
            get_rise();
            $display("idle rise %0d vsync=%0b href=%0b data=%02h", i, ov_vsync, ov_href, ov_data);
            chk($sformatf("idle%0d_vec", i), 32'({ov_vsync, ov_href, ov_data}), 32'(0));
        end
        chk("idle_frame_cnt", 32'(frame_cnt), 32'(fc));
        chk("idle_frame_done_count", 32'(fd_cnt), 32'(fc));
    endtask

    initial begin
        en          = 1'b1;
        pattern_sel = 2'd0;
        rst_n       = 1'b0;
        repeat (3) step();
        chk("reset_outputs", 32'({ov_pclk, ov_vsync, ov_href, ov_data, frame_done}), 32'(0));
        chk("reset_frame_cnt", 32'(frame_cnt), 32'(0));

        // First vsync comes exactly PCLK_DIV cycles after release.
        rst_n = 1'b1;
        repeat (3) step();
        chk("vsync_before_first_tick", 32'(ov_vsync), 32'(0));
        step();
        chk("vsync_at_first_tick", 32'(ov_vsync), 32'(1));

        // Frame 1: ramp.
        start_frame(0, 0, 0);
        check_frame(0, 0, -1, 1'b1, 2'd0);

        // Frame 2: pattern change ignored; en drops in the second active line.
        start_frame(0, 1, 1);
        pattern_sel = 2'd1;
        check_frame(0, 1, 50, 1'b0, 2'd1);
        check_idle(24, 2);

        // Frame 3: colour bars, switch to checker mid-frame.
        en = 1'b1;
        start_frame(1, 2, 2);
        check_frame(1, 2, 40, 1'b1, 2'd2);

        // Frame 4: checker, switch to frame-tagged ramp mid-frame.
        start_frame(2, 3, 3);
        check_frame(2, 3, 40, 1'b1, 2'd3);

        // Frame 5: tagged ramp, then stop.
        start_frame(3, 4, 4);
        check_frame(3, 4, 70, 1'b0, 2'd3);
        check_idle(3, 5);

        // Asynchronous reset in the middle of an active line.
        en          = 1'b1;
        pattern_sel = 2'd0;
        start_frame(0, 5, 5);
        for (int k = 1; k <= 40; k++) check_rise(0, k, 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({ov_pclk, ov_vsync, ov_href, ov_data, frame_done}), 32'(0));
        chk("async_reset_frame_cnt", 32'(frame_cnt), 32'(0));
        repeat (2) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("restart_vsync_before_tick", 32'(ov_vsync), 32'(0));
        step();
        chk("restart_vsync_at_tick", 32'(ov_vsync), 32'(1));
        start_frame(0, 0, 5);
        for (int k = 1; k <= 40; k++) check_rise(0, k, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
